dev_bus_bridge: RTL and testbench
=================================

Name: dev_bus_bridge

Overview:
- Data-side bus bridge between the MIPS32 core's data port and the memory/IO fabric.
- Zero-wait pass-through to data RAM for non-IO addresses.
- IO-window accesses are turned into registered, multi-cycle transactions to one of N_IO peripheral slots. The transaction completes on a slot acknowledge, and a stall is held to the core meanwhile.
- Adds per-access timeout, bus-error reporting and decode of unmapped IO slots.

Parameters:
- N_IO, 4, number of IO peripheral slots (1..8).
- IO_BASE_HI, 16'hBFD0, value of daddr[31:16] that selects the IO window.
- SEL_LSB, 12, LSB of the slot-select field in daddr; the field is daddr[SEL_LSB +: 3].
- TIMEOUT, 16, cycles to wait for io_ack before a bus error (2..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on a bus error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- dce  in  1  core data access enable.
- we  in  4  core byte write enables; 0 means read.
- daddr  in  32  core data address.
- din  in  32  core write data.
- dout  out  32  read data to core.
- stall  out  1  core must hold its request while high.
- bus_err  out  1  one-cycle bus-error pulse.
- data_ce  out  1  RAM chip enable.
- data_we  out  4  RAM byte write enables.
- data_addr  out  32  RAM address.
- data_din  out  32  RAM write data.
- data_dout  in  32  RAM read data.
- io_ce  out  N_IO  one-hot slot enable.
- io_we  out  1  IO write strobe, equal to |we.
- io_be  out  4  IO byte enables.
- io_addr  out  32  IO address.
- io_din  out  32  IO write data.
- io_dout  in  32*N_IO  slot read data; slot k occupies [32k+31:32k].
- io_ack  in  N_IO  slot completion, one per slot.

Behaviour:
- Reset is rst_n, synchronous, active-low. At a clock edge with rst_n=0: state=IDLE, counter=0, io_ce=0, io_we=0, io_be=0, io_addr=0, io_din=0, bus_err=0, captured read data=0.
- While rst_n=0, the combinational outputs are forced: data_ce=0, data_we=0, stall=0, dout=0.
- Decode: io_hit = (daddr[31:16]==IO_BASE_HI); sel = daddr[SEL_LSB +: 3]; unmapped = (sel >= N_IO).
- RAM path is combinational in every state:
  - data_ce = dce & ~io_hit.
  - data_we = we, data_addr = daddr, data_din = din.
  - dout = data_dout when ~io_hit.
- State IDLE:
  - stall = dce & io_hit.
  - On dce & io_hit & unmapped: go to ERR. No io_ce is asserted.
  - On dce & io_hit & mapped: register io_ce[sel]=1, io_we=|we, io_be=we, io_addr=daddr, io_din=din; latch sel; counter=0; go to BUSY.
- State BUSY:
  - stall=1; registered IO outputs are held stable; counter increments each cycle.
  - io_ack[latched sel]=1: capture the io_dout slice into the read register, io_ce=0, go to DONE. Acks from other slots are ignored.
  - counter==TIMEOUT-1 with no ack: io_ce=0, go to ERR.
  - An ack in the same cycle as the timeout wins; the next state is DONE.
- State DONE (one cycle):
  - stall=0, dout = captured data; the core consumes the result this cycle.
  - Next state is IDLE. No new transaction is launched from DONE even though dce is still high.
- State ERR (one cycle):
  - stall=0, dout=ERR_DATA, bus_err=1 (registered on entry, so high exactly this cycle).
  - Writes that end in ERR have no side effect. Next state is IDLE.
- Latency:
  - IO transaction with ack k cycles after io_ce rises (k>=1): stall is high for k+1 cycles, then one DONE cycle.
  - Minimum IO access is 3 cycles, request to consumed.
- Back-to-back IO: a new request presented in the cycle after DONE/ERR starts normally from IDLE.
- Reset mid-transaction: at the reset edge, io_ce drops and state returns to IDLE. A pending ack is ignored.

Test Plan:
- RAM read: daddr=0x0000_1000, dce=1, we=0, data_dout=0x12345678 -> same cycle data_ce=1, dout=0x12345678, stall=0, io_ce=0.
- IO read slot 2: daddr=0xBFD0_2004, io_ack[2] asserted 3 cycles after io_ce=4'b0100, slot data 0xCAFEF00D -> stall high 4 cycles, DONE cycle dout=0xCAFEF00D, bus_err=0.
- IO byte write: daddr=0xBFD0_1000, we=4'b0010, din=0x0000AB00 -> io_ce=4'b0010, io_we=1, io_be=4'b0010, io_din=0x0000AB00 held until ack.
- Timeout: IO read slot 0, no ack -> stall high for TIMEOUT+1=17 cycles, then bus_err=1 for one cycle with dout=0xDEADBEEF, then IDLE.
- Unmapped slot and wrong-slot ack:
  - daddr=0xBFD0_5000 (sel=5) -> no io_ce, ERR next cycle, bus_err=1.
  - Ack on slot 1 while slot 3 is active -> ignored.
- Reset mid-op: rst_n=0 during BUSY -> next edge io_ce=0, state IDLE. A late io_ack produces no DONE. A subsequent IO access works normally.

Source files
------------

// File: rtl/dev_bus_bridge.sv
// rtl/dev_bus_bridge.sv - core data-port bridge: zero-wait RAM pass-through, registered multi-cycle IO slots
module dev_bus_bridge #(
  parameter int          N_IO       = 4,
  parameter logic [15:0] IO_BASE_HI = 16'hBFD0,
  parameter int          SEL_LSB    = 12,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dce,
  input  logic [3:0]        we,
  input  logic [31:0]       daddr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              stall,
  output logic              bus_err,
  output logic              data_ce,
  output logic [3:0]        data_we,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_din,
  input  logic [31:0]       data_dout,
  output logic [N_IO-1:0]   io_ce,
  output logic              io_we,
  output logic [3:0]        io_be,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_din,
  input  logic [32*N_IO-1:0] io_dout,
  input  logic [N_IO-1:0]   io_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]      state;
  logic [7:0]      count;
  logic [2:0]      sel_q;
  logic [31:0]     rd_data;
  logic            io_hit;
  logic [2:0]      sel;
  logic            unmapped;
  logic [N_IO-1:0] sel_onehot;
  logic            ack_hit;
  logic [31:0]     slot_data;

  assign io_hit   = (daddr[31:16] == IO_BASE_HI);
  assign sel      = daddr[SEL_LSB +: 3];
  assign unmapped = ({1'b0, sel} >= 4'(N_IO));

  assign data_addr = daddr;
  assign data_din  = din;

  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (sel == 3'(k)) sel_onehot[k] = 1'b1;
    end
  end

  // Only the latched slot may complete the transaction; other acks are ignored.
  always_comb begin
    ack_hit   = 1'b0;
    slot_data = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (sel_q == 3'(k)) begin
        ack_hit   = io_ack[k];
        slot_data = io_dout[32*k +: 32];
      end
    end
  end

  always_comb begin
    data_ce = dce & ~io_hit;
    data_we = we;
    stall   = 1'b0;
    dout    = '0;
    case (state)
      S_IDLE:  stall = dce & io_hit;
      S_BUSY:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (!io_hit)              dout = data_dout;
    else if (state == S_DONE) dout = rd_data;
    else if (state == S_ERR)  dout = ERR_DATA;
    if (!rst_n) begin
      data_ce = 1'b0;
      data_we = '0;
      stall   = 1'b0;
      dout    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= '0;
      sel_q   <= '0;
      rd_data <= '0;
      io_ce   <= '0;
      io_we   <= 1'b0;
      io_be   <= '0;
      io_addr <= '0;
      io_din  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dce && io_hit) begin
            if (unmapped) begin
              state   <= S_ERR;
              bus_err <= 1'b1;
            end else begin
              io_ce   <= sel_onehot;
              io_we   <= |we;
              io_be   <= we;
              io_addr <= daddr;
              io_din  <= din;
              sel_q   <= sel;
              count   <= '0;
              state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          count <= count + 8'd1;
          if (ack_hit) begin
            rd_data <= slot_data;
            io_ce   <= '0;
            state   <= S_DONE;
          end else if (count == 8'(TIMEOUT - 1)) begin
            io_ce   <= '0;
            state   <= S_ERR;
            bus_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_bus_bridge.sv
// tb/tb_dev_bus_bridge.sv - directed self-checking bench for dev_bus_bridge
module tb_dev_bus_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dce;
  logic [3:0]   we;
  logic [31:0]  daddr;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic         stall;
  logic         bus_err;
  logic         data_ce;
  logic [3:0]   data_we;
  logic [31:0]  data_addr;
  logic [31:0]  data_din;
  logic [31:0]  data_dout;
  logic [3:0]   io_ce;
  logic         io_we;
  logic [3:0]   io_be;
  logic [31:0]  io_addr;
  logic [31:0]  io_din;
  logic [127:0] io_dout;
  logic [3:0]   io_ack;

  int tests = 0;
  int fails = 0;
  int n;

  dev_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .dce(dce), .we(we), .daddr(daddr), .din(din),
    .dout(dout), .stall(stall), .bus_err(bus_err),
    .data_ce(data_ce), .data_we(data_we), .data_addr(data_addr),
    .data_din(data_din), .data_dout(data_dout),
    .io_ce(io_ce), .io_we(io_we), .io_be(io_be), .io_addr(io_addr),
    .io_din(io_din), .io_dout(io_dout), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; dce = 1'b1; we = 4'hF; daddr = 32'h0000_1000; din = 32'h0;
    data_dout = 32'h1111_1111; io_dout = '0; io_ack = '0;
    step; step;
    chk("rst_io_ce", 32'(io_ce), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_data_ce", 32'(data_ce), 32'h0);
    chk("rst_data_we", 32'(data_we), 32'h0);
    chk("rst_dout", dout, 32'h0);
    daddr = 32'hBFD0_2004; #1;
    chk("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1; dce = 1'b0; we = 4'h0;
    step;

    // RAM read pass-through
    daddr = 32'h0000_1000; dce = 1'b1; data_dout = 32'h1234_5678; #1;
    chk("ram_data_ce", 32'(data_ce), 32'h1);
    chk("ram_dout", dout, 32'h1234_5678);
    chk("ram_stall", 32'(stall), 32'h0);
    chk("ram_io_ce", 32'(io_ce), 32'h0);
    chk("ram_addr", data_addr, 32'h0000_1000);
    dce = 1'b0; step;

    // IO read slot 2, ack three cycles after io_ce rises
    io_dout = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0000};
    daddr = 32'hBFD0_2004; dce = 1'b1; we = 4'h0; #1;
    chk("rd_stall_idle", 32'(stall), 32'h1);
    chk("rd_data_ce", 32'(data_ce), 32'h0);
    step;
    chk("rd_io_ce", 32'(io_ce), 32'h4);
    chk("rd_stall_b1", 32'(stall), 32'h1);
    chk("rd_io_addr", io_addr, 32'hBFD0_2004);
    chk("rd_io_we", 32'(io_we), 32'h0);
    step;
    chk("rd_stall_b2", 32'(stall), 32'h1);
    step;
    io_ack = 4'b0100; #1;
    chk("rd_stall_b3", 32'(stall), 32'h1);
    step;
    io_ack = 4'b0000; #1;
    chk("rd_done_stall", 32'(stall), 32'h0);
    chk("rd_done_dout", dout, 32'hCAFE_F00D);
    chk("rd_done_bus_err", 32'(bus_err), 32'h0);
    chk("rd_done_io_ce", 32'(io_ce), 32'h0);
    step;
    // dce still high: DONE must not have launched a new transaction
    chk("rd_no_relaunch_io_ce", 32'(io_ce), 32'h0);
    chk("rd_idle_stall", 32'(stall), 32'h1);
    dce = 1'b0; step;

    // IO byte write slot 1
    daddr = 32'hBFD0_1000; we = 4'b0010; din = 32'h0000_AB00; dce = 1'b1;
    step;
    chk("wr_io_ce", 32'(io_ce), 32'h2);
    chk("wr_io_we", 32'(io_we), 32'h1);
    chk("wr_io_be", 32'(io_be), 32'h2);
    chk("wr_io_din", io_din, 32'h0000_AB00);
    din = 32'hFFFF_FFFF;
    step;
    chk("wr_io_din_held", io_din, 32'h0000_AB00);
    chk("wr_io_ce_held", 32'(io_ce), 32'h2);
    io_ack = 4'b0010;
    step;
    io_ack = 4'b0000; #1;
    chk("wr_done_stall", 32'(stall), 32'h0);
    chk("wr_done_bus_err", 32'(bus_err), 32'h0);
    dce = 1'b0; we = 4'h0; step;

    // Timeout on slot 0
    daddr = 32'hBFD0_0000; dce = 1'b1; #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      n++;
      step;
    end
    chk("to_stall_cycles", 32'(n), 32'd17);
    chk("to_bus_err", 32'(bus_err), 32'h1);
    chk("to_dout", dout, 32'hDEAD_BEEF);
    dce = 1'b0; step;
    chk("to_bus_err_clear", 32'(bus_err), 32'h0);
    chk("to_idle_stall", 32'(stall), 32'h0);

    // Unmapped slot 5 write: straight to ERR, no slot enabled
    daddr = 32'hBFD0_5000; we = 4'hF; din = 32'h5555_5555; dce = 1'b1; #1;
    chk("um_stall_idle", 32'(stall), 32'h1);
    step;
    chk("um_io_ce", 32'(io_ce), 32'h0);
    chk("um_bus_err", 32'(bus_err), 32'h1);
    chk("um_stall", 32'(stall), 32'h0);
    chk("um_dout", dout, 32'hDEAD_BEEF);
    dce = 1'b0; we = 4'h0; step;

    // Wrong-slot ack ignored while slot 3 active
    io_dout = {32'h5A5A_5A5A, 32'h0, 32'h6666_6666, 32'h0};
    daddr = 32'hBFD0_3000; dce = 1'b1;
    step;
    chk("ws_io_ce", 32'(io_ce), 32'h8);
    io_ack = 4'b0010;
    step;
    chk("ws_stall", 32'(stall), 32'h1);
    chk("ws_io_ce_held", 32'(io_ce), 32'h8);
    io_ack = 4'b1000;
    step;
    io_ack = 4'b0000; #1;
    chk("ws_done_dout", dout, 32'h5A5A_5A5A);
    chk("ws_done_stall", 32'(stall), 32'h0);
    dce = 1'b0; step;

    // Reset mid-transaction, late ack ignored, then a normal access
    io_dout = {32'h0, 32'h7777_7777, 32'h0, 32'h0};
    daddr = 32'hBFD0_2000; dce = 1'b1;
    step;
    chk("rm_io_ce", 32'(io_ce), 32'h4);
    rst_n = 1'b0; #1;
    chk("rm_stall_forced", 32'(stall), 32'h0);
    chk("rm_dout_forced", dout, 32'h0);
    step;
    chk("rm_io_ce_clear", 32'(io_ce), 32'h0);
    rst_n = 1'b1; dce = 1'b0; io_ack = 4'b0100;
    step;
    io_ack = 4'b0000; dce = 1'b1; #1;
    chk("rm_late_ack_idle", 32'(stall), 32'h1);
    chk("rm_late_ack_bus_err", 32'(bus_err), 32'h0);
    step;
    chk("rm_new_io_ce", 32'(io_ce), 32'h4);
    io_dout = {32'h0, 32'h0BAD_F00D, 32'h0, 32'h0};
    io_ack = 4'b0100;
    step;
    io_ack = 4'b0000; #1;
    chk("rm_new_dout", dout, 32'h0BAD_F00D);
    chk("rm_new_stall", 32'(stall), 32'h0);
    dce = 1'b0; step;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
